// File: rtl/vec_pkg.sv
// Shared definitions for the vector ASIP: ALU control codes, execute-stage states
// and default lane geometry.
package vec_pkg;

   localparam int unsigned VEC_LANES = 4;
   localparam int unsigned VEC_W     = 8;

   // Encodings shared with the decoder; 3'b110/3'b111 are treated as NOP.
   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_PASS = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_MUL  = 3'b100,
      OP_DIV  = 3'b101
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_HOLD = 2'd2
   } exec_state_t;

endpackage

// File: rtl/lane_divider.sv
// Single-lane restoring divider: one quotient bit per cycle, W cycles after start.
// A zero divisor saturates the quotient to all ones.
module lane_divider
   import vec_pkg::*;
#(
   parameter int unsigned W = VEC_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         done,
   output logic [W-1:0] quo
);

   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   logic          active_q, active_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  rem_q, rem_d;
   logic [W-1:0]  quo_q, quo_d;
   logic [W-1:0]  div_q, div_d;

   logic [W:0]    rem_sh;
   logic          ge;
   logic [W-1:0]  quo_step;
   logic [W-1:0]  rem_step;

   always_comb begin
      // quo_q starts as the dividend and shifts out MSB-first as quotient bits shift in
      rem_sh   = {rem_q, quo_q[W-1]};
      ge       = rem_sh >= {1'b0, div_q};
      quo_step = {quo_q[W-2:0], ge};
      rem_step = ge ? (rem_sh[W-1:0] - div_q) : rem_sh[W-1:0];

      done = active_q && (cnt_q == CW'(W - 1));
      quo  = (div_q == '0) ? '1 : quo_step;

      active_d = active_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      div_d    = div_q;
      if (start) begin
         active_d = 1'b1;
         cnt_d    = '0;
         rem_d    = '0;
         quo_d    = a;
         div_d    = b;
      end else if (active_q) begin
         rem_d = rem_step;
         quo_d = quo_step;
         cnt_d = cnt_q + 1'b1;
         if (done) active_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         div_q    <= '0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         div_q    <= div_d;
      end
   end

endmodule

// File: rtl/vec_alu_exec.sv
// Vector ASIP execute stage: lane-wise pass / saturating add-sub / normalised
// multiply in one cycle, iterative divide over W cycles, valid/ready on both sides.
module vec_alu_exec
   import vec_pkg::*;
#(
   parameter int unsigned LANES = VEC_LANES,
   parameter int unsigned W     = VEC_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         alu_op,
   input  logic [LANES*W-1:0] op_a,
   input  logic [LANES*W-1:0] op_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES*W-1:0] result,
   output logic               busy
);

   exec_state_t        state_q, state_d;
   logic [LANES*W-1:0] result_q, result_d;
   logic [LANES*W-1:0] alu_res;
   logic [LANES*W-1:0] div_quo;
   logic [LANES-1:0]   div_done;
   logic               accept;
   logic               div_start;

   assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
   assign accept    = in_valid && in_ready;
   assign div_start = accept && (alu_op == OP_DIV);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [W-1:0]   a, b, lane_res;
      logic [W:0]     sum;
      logic [2*W:0]   prod, norm;

      always_comb begin
         a    = op_a[i*W +: W];
         b    = op_b[i*W +: W];
         sum  = {1'b0, a} + {1'b0, b};
         // rounded a*b/(2^W-1) without a divider
         prod = ({{(W+1){1'b0}}, a} * {{(W+1){1'b0}}, b}) + ((2*W+1)'(1) << (W - 1));
         norm = prod + (prod >> W);
         case (alu_op)
            OP_PASS: lane_res = a;
            OP_ADD:  lane_res = sum[W] ? '1 : sum[W-1:0];
            OP_SUB:  lane_res = (a > b) ? (a - b) : '0;
            OP_MUL:  lane_res = norm[W +: W];
            default: lane_res = '0;
         endcase
      end

      assign alu_res[i*W +: W] = lane_res;

      lane_divider #(.W(W)) u_div (
         .clk   (clk),
         .rst_n (rst_n),
         .start (div_start),
         .a     (a),
         .b     (b),
         .done  (div_done[i]),
         .quo   (div_quo[i*W +: W])
      );
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE, ST_HOLD: begin
            if (accept) begin
               case (alu_op)
                  OP_PASS, OP_ADD, OP_SUB, OP_MUL: begin
                     result_d = alu_res;
                     state_d  = ST_HOLD;
                  end
                  OP_DIV:  state_d = ST_DIV;
                  default: state_d = ST_IDLE;
               endcase
            end else if ((state_q == ST_HOLD) && out_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_DIV: begin
            if (&div_done) begin
               result_d = div_quo;
               state_d  = ST_HOLD;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
      end
   end

   assign out_valid = (state_q == ST_HOLD);
   assign busy      = (state_q == ST_DIV);
   assign result    = result_q;

endmodule

// File: tb/tb_vec_alu_exec.sv
// Directed bench for vec_alu_exec with hand-computed lane results.
module tb_vec_alu_exec;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  alu_op = 3'b000;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        busy;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   vec_alu_exec #(.LANES(4), .W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one transaction at the negedge, confirm it is accepted, and return #1 after the edge.
   task automatic send(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
      @(negedge clk);
      alu_op   = op;
      op_a     = a;
      op_b     = b;
      in_valid = 1'b1;
      #1;
      check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   logic        seen_valid;
   logic [31:0] held;

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", result, 32'h0);
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // single-cycle ops issued back to back with out_ready=1
      send("pass", 3'b001, 32'h11223344, 32'h0);
      check("pass_valid", {31'd0, out_valid}, 32'd1);
      check("pass_res", result, 32'h11223344);
      send("add", 3'b010, 32'hF0108000, 32'h20108080);
      check("add_res", result, 32'hFF20FF80);
      send("sub", 3'b011, 32'hF0108000, 32'h20108080);
      check("sub_res", result, 32'hD0000000);
      send("mul", 3'b100, 32'hFF80FF00, 32'hFF80007F);
      check("mul_res", result, 32'hFF400000);
      send("mul2", 3'b100, 32'h40FF0102, 32'h40017FFF);
      check("mul2_res", result, 32'h10010002);
      send("nop", 3'b110, 32'h12345678, 32'h12345678);
      check("nop_valid", {31'd0, out_valid}, 32'd0);

      // divide with a zero-divisor lane; upstream holds a PASS while busy
      out_ready = 1'b0;
      send("div", 3'b101, 32'hC805FF07, 32'h07000108);
      alu_op   = 3'b001;
      op_a     = 32'hDEADBEEF;
      in_valid = 1'b1;
      for (int unsigned k = 1; k <= 9; k++) begin
         if (k > 1) begin
            @(posedge clk);
            #1;
         end
         if (k <= 8) begin
            check($sformatf("div_busy%0d", k), {31'd0, busy}, 32'd1);
            check($sformatf("div_rdy%0d", k), {31'd0, in_ready}, 32'd0);
            check($sformatf("div_ov%0d", k), {31'd0, out_valid}, 32'd0);
         end
      end
      check("div_valid", {31'd0, out_valid}, 32'd1);
      check("div_busy_end", {31'd0, busy}, 32'd0);
      check("div_res", result, 32'h1CFFFF00);

      // backpressure: result and out_valid hold while the consumer stalls
      held = result;
      for (int unsigned k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp_res%0d", k), result, held);
         check($sformatf("bp_ov%0d", k), {31'd0, out_valid}, 32'd1);
         check($sformatf("bp_rdy%0d", k), {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      alu_op    = 3'b010;
      op_a      = 32'h01020304;
      op_b      = 32'h10203040;
      #1;
      check("bp_release_rdy", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_new_valid", {31'd0, out_valid}, 32'd1);
      check("bp_new_res", result, 32'h11223344);
      @(posedge clk);
      #1;
      check("bp_drain", {31'd0, out_valid}, 32'd0);

      // reset during the fourth divide iteration
      send("div2", 3'b101, 32'hFFFFFFFF, 32'h01010101);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_res", result, 32'h0);
      check("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         seen_valid = seen_valid | out_valid | busy;
      end
      check("no_stale", {31'd0, seen_valid}, 32'd0);
      send("pass2", 3'b001, 32'hA5A55A5A, 32'h0);
      check("pass2_res", result, 32'hA5A55A5A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
